// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state type and the divide-by-zero LO pattern.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_e;

    // Sliced down to the instance WIDTH by users (WIDTH <= 64).
    localparam int unsigned DIV0_W = 64;
    localparam logic [DIV0_W-1:0] DIV0_LO = {DIV0_W{1'b1}};

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division iteration: shifts the next dividend
// bit into the partial remainder and produces one quotient bit.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0] shifted_s;

    // Trial subtract; the difference always fits WIDTH bits when it is kept.
    always_comb begin
        shifted_s = {rem_i, quot_i[WIDTH-1]};
        if (shifted_s >= {1'b0, divisor_i}) begin
            rem_o  = shifted_s[WIDTH-1:0] - divisor_i;
            quot_o = {quot_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o  = shifted_s[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU) with MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   breg_q, breg_d;
    logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               signed_op_s, is_div_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_abs_s, b_abs_s, addend_s, div_rem_s, div_quot_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s, prod_fix_s;
    logic [WIDTH-1:0]   quot_fix_s, rem_fix_s;

    // Operand sign handling for the request presented this cycle.
    always_comb begin
        signed_op_s = (op == OP_MULT) || (op == OP_DIV);
        is_div_s    = (op == OP_DIV) || (op == OP_DIVU);
        a_neg_s     = signed_op_s & operand_a[WIDTH-1];
        b_neg_s     = signed_op_s & operand_b[WIDTH-1];
        a_abs_s     = a_neg_s ? -operand_a : operand_a;
        b_abs_s     = b_neg_s ? -operand_b : operand_b;
    end

    // Shift-add multiply step: acc = {partial product, remaining multiplier}.
    always_comb begin
        if (acc_q[0]) begin
            addend_s = breg_q;
        end else begin
            addend_s = ZERO_W;
        end
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
        mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end

    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
        .quot_i    (acc_q[WIDTH-1:0]),
        .divisor_i (breg_q),
        .rem_o     (div_rem_s),
        .quot_o    (div_quot_s)
    );

    // Sign correction applied on the FIXUP edge.
    always_comb begin
        prod_fix_s = neg_res_q ? -acc_q : acc_q;
        quot_fix_s = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix_s  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_a_s, fast_b_s, fast_prod_s;

    // Sign-extended full-width multiply; low 2*WIDTH bits are exact.
    always_comb begin
        fast_a_s    = signed_op_s ? {{WIDTH{operand_a[WIDTH-1]}}, operand_a} : {ZERO_W, operand_a};
        fast_b_s    = signed_op_s ? {{WIDTH{operand_b[WIDTH-1]}}, operand_b} : {ZERO_W, operand_b};
        fast_prod_s = fast_a_s * fast_b_s;
    end
`endif

    // Next-state logic for the FSM, datapath and HI/LO registers.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        breg_d    = breg_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op;
                    cnt_d     = {CNT_W{1'b0}};
                    busy_d    = 1'b1;
                    neg_res_d = 1'b0;
                    neg_rem_d = 1'b0;
                    if (is_div_s) begin
                        breg_d = b_abs_s;
                        // Special divides preload the final result and skip CALC.
                        if (operand_b == ZERO_W) begin
                            acc_d   = {operand_a, DIV0_LO[WIDTH-1:0]};
                            state_d = FIXUP;
                        end else if ((op == OP_DIV) && (operand_a == MIN_NEG) && (operand_b == ONES_W)) begin
                            acc_d   = {ZERO_W, MIN_NEG};
                            state_d = FIXUP;
                        end else begin
                            acc_d     = {ZERO_W, a_abs_s};
                            neg_res_d = a_neg_s ^ b_neg_s;
                            neg_rem_d = a_neg_s;
                            state_d   = CALC;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = fast_prod_s;
                        state_d = FIXUP;
`else
                        acc_d     = {ZERO_W, b_abs_s};
                        breg_d    = a_abs_s;
                        neg_res_d = a_neg_s ^ b_neg_s;
                        state_d   = CALC;
`endif
                    end
                end else begin
                    if (mthi_en) begin
                        hi_d = mt_data;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (mtlo_en) begin
                        lo_d = mt_data;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            CALC: begin
                if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
                    acc_d = {div_rem_s, div_quot_s};
                end else begin
                    acc_d = mul_next_s;
                end
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end else begin
                    state_d = CALC;
                end
            end
            FIXUP: begin
                if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
                    hi_d = rem_fix_s;
                    lo_d = quot_fix_s;
                end else begin
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= 2'd0;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            breg_q    <= ZERO_W;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            breg_q    <= breg_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit plus hand-written sequences
// for busy-time ignores, MT writes and reset abort.
module tb_muldiv_unit;

    localparam logic [1:0] T_MULT  = 2'd0;
    localparam logic [1:0] T_MULTU = 2'd1;
    localparam logic [1:0] T_DIV   = 2'd2;
    localparam logic [1:0] T_DIVU  = 2'd3;
`ifdef MULDIV_FAST_MUL_EN
    localparam int ML  = 2;
    localparam int INJ = 1;
`else
    localparam int ML  = 34;
    localparam int INJ = 10;
`endif
    localparam int DL = 34;
    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst, start, mthi_en, mtlo_en, busy, done;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, mt_data, hi, lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .mthi_en   (mthi_en),
        .mtlo_en   (mtlo_en),
        .mt_data   (mt_data),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op and wait (bounded) for done; lat counts edges from E0.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_bad);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
        lat = 1; busy_bad = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bb, e, ndone;

        vecs[0]  = '{T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, ML};
        vecs[1]  = '{T_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, ML};
        vecs[2]  = '{T_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, ML};
        vecs[3]  = '{T_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, ML};
        vecs[4]  = '{T_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, ML};
        vecs[5]  = '{T_MULT,  32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, ML};
        vecs[6]  = '{T_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DL};
        vecs[7]  = '{T_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DL};
        vecs[8]  = '{T_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DL};
        vecs[9]  = '{T_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, DL};
        vecs[10] = '{T_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, DL};
        vecs[11] = '{T_DIVU,  32'h00000005, 32'h00000010, 32'h00000005, 32'h00000000, DL};
        vecs[12] = '{T_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 2};
        vecs[13] = '{T_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 2};
        vecs[14] = '{T_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 2};
        vecs[15] = '{T_DIV,   32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000, DL};

        rst = 1'b1; start = 1'b0; op = 2'd0; operand_a = 32'd0; operand_b = 32'd0;
        mthi_en = 1'b0; mtlo_en = 1'b0; mt_data = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);

        // Vectors run back to back: each start lands in the previous done cycle.
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bb);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_during", i), bb, 0);
            chk($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
        end

        // Start and MTHI while busy must be ignored.
        op = T_MULTU; operand_a = 32'd5; operand_b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; e = 0;
        while (done !== 1'b1 && e < 100) begin
            if (e + 1 == INJ) begin
                start = 1'b1; op = T_DIVU; operand_a = 32'd1000; operand_b = 32'd3;
                mthi_en = 1'b1; mt_data = 32'h55;
            end
            @(posedge clk); #1;
            e++;
            start = 1'b0; mthi_en = 1'b0;
        end
        chk("ign_latency", e + 1, ML);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd30);
        @(posedge clk); #1;
        chk("done_pulse_width", done, 1'b0);
        chk("ign_no_second_op", busy, 1'b0);

        mthi_en = 1'b1; mt_data = 32'hAA;
        @(posedge clk); #1 mthi_en = 1'b0;
        chk("mthi_hi", hi, 32'hAA);
        chk("mthi_lo_kept", lo, 32'd30);

        mthi_en = 1'b1; mtlo_en = 1'b1; mt_data = 32'h77;
        @(posedge clk); #1 mthi_en = 1'b0; mtlo_en = 1'b0;
        chk("mt_both_hi", hi, 32'h77);
        chk("mt_both_lo", lo, 32'h77);

        // Start wins over a same-cycle MT write.
        mthi_en = 1'b1; mtlo_en = 1'b1; mt_data = 32'hDEAD;
        run_op(T_DIVU, 32'd100, 32'd7, lat, bb);
        chk("start_wins_latency", lat, DL);
        chk("start_wins_hi", hi, 32'd2);
        chk("start_wins_lo", lo, 32'd14);

        // Reset at edge 15 of a DIV aborts it with no done pulse.
        op = T_DIV; operand_a = 32'hFFFFFFF9; operand_b = 32'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) ndone++;
        end
        chk("abort_no_done_later", ndone, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
